// File: rtl/sram_req_adapter.sv
// sram_req_adapter
//   Valid/ready front end for a synchronous single-port N x 32-bit RAM with
//   byte enables. Requests are turned into RAM strobes combinationally. Each
//   accepted request is tracked through a RAM_LATENCY-deep in-flight pipe.
//   Its response is offered directly from the RAM read port (bypass) or from
//   a small first-word-fall-through FIFO. A credit counter bounds in-flight
//   plus stored responses to RESP_DEPTH, so the RAM never has to be stalled
//   mid-access and the FIFO cannot overflow. Responses come back strictly in
//   acceptance order, one per request.
//
// Optional feature (compile-time macro SRAM_REQ_ADAPTER_ADDR_CHECK_EN):
//   Defined   : addresses >= DATA_DEPTH are accepted but never reach the RAM.
//               They are answered in order with RespErr_SO=1 and data 0.
//   Undefined : the error flag is constant 0, so RespErr_SO is always 0.
//               Every address goes to the RAM unchanged.
//
// Ports
//   Clk_CI, Rst_RBI    clock, asynchronous active-low reset
//   ReqValid_SI/ReqReady_SO, ReqWrEn_SI, ReqBEn_SI, ReqAddr_DI, ReqWrData_DI
//                      request channel
//   RespValid_SO/RespReady_SI, RespRdData_DO, RespWr_SO, RespErr_SO
//                      response channel (RdData is 0 for write/error responses)
//   RamCSel_SO, RamWrEn_SO, RamBEn_SO, RamAddr_DO, RamWrData_DO, RamRdData_DI
//                      RAM port
//   Idle_SO            no request in flight and no response stored
module sram_req_adapter #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_DEPTH  = 1024,
  parameter int RAM_LATENCY = 1,
  parameter int RESP_DEPTH  = 2
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  ReqValid_SI,
  output logic                  ReqReady_SO,
  input  logic                  ReqWrEn_SI,
  input  logic [3:0]            ReqBEn_SI,
  input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
  input  logic [31:0]           ReqWrData_DI,
  output logic                  RespValid_SO,
  input  logic                  RespReady_SI,
  output logic [31:0]           RespRdData_DO,
  output logic                  RespWr_SO,
  output logic                  RespErr_SO,
  output logic                  RamCSel_SO,
  output logic                  RamWrEn_SO,
  output logic [3:0]            RamBEn_SO,
  output logic [ADDR_WIDTH-1:0] RamAddr_DO,
  output logic [31:0]           RamWrData_DO,
  input  logic [31:0]           RamRdData_DI,
  output logic                  Idle_SO
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);

  if (DATA_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("DATA_DEPTH must not exceed 2**ADDR_WIDTH");
  end
  if (RESP_DEPTH < RAM_LATENCY) begin : g_bad_resp_depth
    $error("RESP_DEPTH must be >= RAM_LATENCY");
  end

  // Explicit wrap so non-power-of-two FIFO depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic                  err;
  logic                  accept;
  logic                  resp_hs;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [RAM_LATENCY-1:0] vld_p;
  logic [RAM_LATENCY-1:0] wr_p;
  logic [RAM_LATENCY-1:0] err_p;
  logic                  last_vld;
  logic                  last_wr;
  logic                  last_err;
  logic [DATA_W-1:0]     last_data;
  logic [DATA_W-1:0]     mem_data [RESP_DEPTH];
  logic                  mem_wr   [RESP_DEPTH];
  logic                  mem_err  [RESP_DEPTH];

`ifdef SRAM_REQ_ADAPTER_ADDR_CHECK_EN
  // Extra MSB keeps the compare correct when DATA_DEPTH == 2**ADDR_WIDTH.
  assign err = ({1'b0, ReqAddr_DI} >= (ADDR_WIDTH + 1)'(DATA_DEPTH));
`else
  assign err = 1'b0;
`endif

  // ---- request side: credit check and RAM drive ----
  // Ready is gated by reset so nothing is accepted while Rst_RBI is low. The
  // RespReady_SI term frees a credit in the same cycle a response leaves.
  assign resp_hs     = RespValid_SO & RespReady_SI;
  assign ReqReady_SO = Rst_RBI & ((cnt < CNT_MAX) | resp_hs);
  assign accept      = ReqValid_SI & ReqReady_SO;

  assign RamCSel_SO   = accept & ~err;
  assign RamWrEn_SO   = ReqWrEn_SI;
  assign RamBEn_SO    = ReqBEn_SI;
  assign RamAddr_DO   = ReqAddr_DI;
  assign RamWrData_DO = ReqWrData_DI;

  // ---- in-flight pipe: stage 0 loads on accept; last stage = RdData valid ----
  if (RAM_LATENCY == 1) begin : g_lat1
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) vld_p <= '0;
      else          vld_p <= accept;
    end
    always_ff @(posedge Clk_CI) begin
      wr_p  <= ReqWrEn_SI;
      err_p <= err;
    end
  end else begin : g_latn
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) vld_p <= '0;
      else          vld_p <= {vld_p[RAM_LATENCY-2:0], accept};
    end
    always_ff @(posedge Clk_CI) begin
      wr_p  <= {wr_p[RAM_LATENCY-2:0], ReqWrEn_SI};
      err_p <= {err_p[RAM_LATENCY-2:0], err};
    end
  end

  assign last_vld  = vld_p[RAM_LATENCY-1];
  assign last_wr   = wr_p[RAM_LATENCY-1];
  assign last_err  = err_p[RAM_LATENCY-1];
  assign last_data = (last_wr | last_err) ? '0 : RamRdData_DI;

  // ---- response side: FWFT FIFO with bypass from the RAM read port ----
  assign fifo_empty = (fifo_cnt == '0);
  // A returning response bypasses the FIFO only when the FIFO is empty and
  // the consumer takes it right away; otherwise it must be stored.
  assign push = last_vld & ~(fifo_empty & RespReady_SI);
  assign pop  = ~fifo_empty & RespReady_SI;

  assign RespValid_SO  = ~fifo_empty | last_vld;
  assign RespRdData_DO = fifo_empty ? last_data : mem_data[rd_ptr];
  assign RespWr_SO     = fifo_empty ? last_wr   : mem_wr[rd_ptr];
  assign RespErr_SO    = fifo_empty ? last_err  : mem_err[rd_ptr];

  assign Idle_SO = (cnt == '0);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      cnt      <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      case ({accept, resp_hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (push) begin
      mem_data[wr_ptr] <= last_data;
      mem_wr[wr_ptr]   <= last_wr;
      mem_err[wr_ptr]  <= last_err;
    end
  end

endmodule
